// File: rtl/up_bus_resp_mux.sv
`default_nettype none
// ============================================================================
// Module   : up_bus_resp_mux
// Purpose  : Broadcasts up-bus requests to all slaves, merges acks/read data,
//            guarantees completion via timeout, and keeps debug status.
// Revision : 1.0 - initial release
// ============================================================================
module up_bus_resp_mux #(
  parameter int          NUM_SLAVES   = 3,
  parameter int          ADDR_WIDTH   = 14,
  parameter int          TIMEOUT      = 32,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADDEAD
) (
  input  logic                       up_clk,
  input  logic                       up_rstn,
  input  logic                       up_wreq,
  input  logic [ADDR_WIDTH-1:0]      up_waddr,
  input  logic [31:0]                up_wdata,
  output logic                       up_wack,
  input  logic                       up_rreq,
  input  logic [ADDR_WIDTH-1:0]      up_raddr,
  output logic [31:0]                up_rdata,
  output logic                       up_rack,
  output logic                       slv_wreq,
  output logic [ADDR_WIDTH-1:0]      slv_waddr,
  output logic [31:0]                slv_wdata,
  input  logic [NUM_SLAVES-1:0]      slv_wack,
  output logic                       slv_rreq,
  output logic [ADDR_WIDTH-1:0]      slv_raddr,
  input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
  input  logic [NUM_SLAVES-1:0]      slv_rack,
  input  logic                       up_status_clr,
  output logic [15:0]                up_timeout_cnt,
  output logic [ADDR_WIDTH-1:0]      up_timeout_addr,
  output logic                       up_multi_ack_err,
  output logic                       up_proto_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] c_last_cnt = 8'(TIMEOUT - 1);

  state_t      r_wstate, w_wstate_nxt;
  state_t      r_rstate, w_rstate_nxt;
  logic [7:0]  r_wcnt, w_wcnt_nxt;
  logic [7:0]  r_rcnt, w_rcnt_nxt;
  logic        w_waccept, w_wdone, w_wtimeout;
  logic        w_raccept, w_rdone, w_rtimeout;
  logic        w_wmulti, w_rmulti, w_wproto, w_rproto;
  logic [31:0] w_rdata_or;
  logic [1:0]  w_tinc;
  logic [16:0] w_tsum;

  // ---------------- write path ----------------
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wcnt_nxt   = r_wcnt;
    w_waccept    = 1'b0;
    w_wdone      = 1'b0;
    w_wtimeout   = 1'b0;
    case (r_wstate)
      S_IDLE: begin
        if (up_wreq) begin
          w_waccept    = 1'b1;
          w_wcnt_nxt   = 8'd0;
          w_wstate_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // an ack arriving together with the timeout still counts as a normal completion
        if (|slv_wack) begin
          w_wdone      = 1'b1;
          w_wstate_nxt = S_IDLE;
        end else if (r_wcnt == c_last_cnt) begin
          w_wdone      = 1'b1;
          w_wtimeout   = 1'b1;
          w_wstate_nxt = S_IDLE;
        end else begin
          w_wcnt_nxt = r_wcnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      r_wstate  <= S_IDLE;
      r_wcnt    <= 8'd0;
      slv_wreq  <= 1'b0;
      slv_waddr <= '0;
      slv_wdata <= 32'd0;
      up_wack   <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wcnt   <= w_wcnt_nxt;
      slv_wreq <= w_waccept;
      up_wack  <= w_wdone;
      if (w_waccept) begin
        slv_waddr <= up_waddr;
        slv_wdata <= up_wdata;
      end
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rcnt_nxt   = r_rcnt;
    w_raccept    = 1'b0;
    w_rdone      = 1'b0;
    w_rtimeout   = 1'b0;
    case (r_rstate)
      S_IDLE: begin
        if (up_rreq) begin
          w_raccept    = 1'b1;
          w_rcnt_nxt   = 8'd0;
          w_rstate_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (|slv_rack) begin
          w_rdone      = 1'b1;
          w_rstate_nxt = S_IDLE;
        end else if (r_rcnt == c_last_cnt) begin
          w_rdone      = 1'b1;
          w_rtimeout   = 1'b1;
          w_rstate_nxt = S_IDLE;
        end else begin
          w_rcnt_nxt = r_rcnt + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    w_rdata_or = 32'd0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slv_rack[i]) w_rdata_or = w_rdata_or | slv_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      r_rstate  <= S_IDLE;
      r_rcnt    <= 8'd0;
      slv_rreq  <= 1'b0;
      slv_raddr <= '0;
      up_rack   <= 1'b0;
      up_rdata  <= 32'd0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_rcnt   <= w_rcnt_nxt;
      slv_rreq <= w_raccept;
      up_rack  <= w_rdone;
      if (w_raccept) slv_raddr <= up_raddr;
      if (w_rdone)   up_rdata  <= w_rtimeout ? TIMEOUT_DATA : w_rdata_or;
    end
  end

  // ---------------- debug status ----------------
  assign w_wmulti = (r_wstate == S_WAIT) && ($countones(slv_wack) > 1);
  assign w_rmulti = (r_rstate == S_WAIT) && ($countones(slv_rack) > 1);
  assign w_wproto = (r_wstate == S_WAIT) && up_wreq;
  assign w_rproto = (r_rstate == S_WAIT) && up_rreq;
  assign w_tinc   = {1'b0, w_wtimeout} + {1'b0, w_rtimeout};
  assign w_tsum   = {1'b0, up_timeout_cnt} + {15'd0, w_tinc};

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      up_timeout_cnt   <= 16'd0;
      up_timeout_addr  <= '0;
      up_multi_ack_err <= 1'b0;
      up_proto_err     <= 1'b0;
    end else if (up_status_clr) begin
      up_timeout_cnt   <= 16'd0;
      up_timeout_addr  <= '0;
      up_multi_ack_err <= 1'b0;
      up_proto_err     <= 1'b0;
    end else begin
      up_timeout_cnt <= w_tsum[16] ? 16'hFFFF : w_tsum[15:0];
      // simultaneous timeouts report the write address
      if (w_wtimeout)      up_timeout_addr <= slv_waddr;
      else if (w_rtimeout) up_timeout_addr <= slv_raddr;
      if (w_wmulti || w_rmulti) up_multi_ack_err <= 1'b1;
      if (w_wproto || w_rproto) up_proto_err     <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_up_bus_resp_mux.sv
`default_nettype none
// Testbench for up_bus_resp_mux: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_up_bus_resp_mux;
  localparam int          NS = 3;
  localparam int          AW = 14;
  localparam int          TO = 32;
  localparam logic [31:0] TD = 32'hDEADDEAD;

  logic              up_clk = 1'b0;
  logic              up_rstn = 1'b0;
  logic              up_wreq = 1'b0;
  logic [AW-1:0]     up_waddr = '0;
  logic [31:0]       up_wdata = '0;
  logic              up_wack;
  logic              up_rreq = 1'b0;
  logic [AW-1:0]     up_raddr = '0;
  logic [31:0]       up_rdata;
  logic              up_rack;
  logic              slv_wreq;
  logic [AW-1:0]     slv_waddr;
  logic [31:0]       slv_wdata;
  logic [NS-1:0]     slv_wack = '0;
  logic              slv_rreq;
  logic [AW-1:0]     slv_raddr;
  logic [32*NS-1:0]  slv_rdata = '0;
  logic [NS-1:0]     slv_rack = '0;
  logic              up_status_clr = 1'b0;
  logic [15:0]       up_timeout_cnt;
  logic [AW-1:0]     up_timeout_addr;
  logic              up_multi_ack_err;
  logic              up_proto_err;

  up_bus_resp_mux #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .TIMEOUT(TO), .TIMEOUT_DATA(TD)) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .slv_wreq(slv_wreq), .slv_waddr(slv_waddr), .slv_wdata(slv_wdata), .slv_wack(slv_wack),
    .slv_rreq(slv_rreq), .slv_raddr(slv_raddr), .slv_rdata(slv_rdata), .slv_rack(slv_rack),
    .up_status_clr(up_status_clr), .up_timeout_cnt(up_timeout_cnt),
    .up_timeout_addr(up_timeout_addr), .up_multi_ack_err(up_multi_ack_err),
    .up_proto_err(up_proto_err)
  );

  always #5 up_clk = ~up_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int            m_n = 0;
  bit            m_wbusy = 0, m_rbusy = 0;
  int            m_wstart = 0, m_rstart = 0;
  logic          e_slv_wreq = 0, e_slv_rreq = 0, e_wack = 0, e_rack = 0;
  logic [AW-1:0] e_slv_waddr = '0, e_slv_raddr = '0, e_taddr = '0;
  logic [31:0]   e_slv_wdata = '0, e_rdata = '0;
  int            e_tcnt = 0;
  logic          e_multi = 0, e_proto = 0;

  task automatic model_reset();
    m_wbusy = 0; m_rbusy = 0;
    e_slv_wreq = 0; e_slv_rreq = 0; e_wack = 0; e_rack = 0;
    e_slv_waddr = '0; e_slv_raddr = '0; e_taddr = '0;
    e_slv_wdata = '0; e_rdata = '0;
    e_tcnt = 0; e_multi = 0; e_proto = 0;
  endtask

  task automatic model_step();
    bit wto, rto, multi_set, proto_set;
    logic [31:0] merged;
    wto = 0; rto = 0; multi_set = 0; proto_set = 0;
    e_slv_wreq = 0; e_slv_rreq = 0; e_wack = 0; e_rack = 0;
    m_n++;
    if (!m_wbusy) begin
      if (up_wreq) begin
        m_wbusy = 1; m_wstart = m_n; e_slv_wreq = 1;
        e_slv_waddr = up_waddr; e_slv_wdata = up_wdata;
      end
    end else begin
      if (up_wreq) proto_set = 1;
      if ($countones(slv_wack) > 1) multi_set = 1;
      if (slv_wack != '0) begin
        e_wack = 1; m_wbusy = 0;
      end else if (m_n - m_wstart == TO) begin
        e_wack = 1; m_wbusy = 0; wto = 1;
      end
    end
    if (!m_rbusy) begin
      if (up_rreq) begin
        m_rbusy = 1; m_rstart = m_n; e_slv_rreq = 1; e_slv_raddr = up_raddr;
      end
    end else begin
      if (up_rreq) proto_set = 1;
      if ($countones(slv_rack) > 1) multi_set = 1;
      if (slv_rack != '0) begin
        merged = '0;
        for (int i = 0; i < NS; i++) if (slv_rack[i]) merged = merged | slv_rdata[32*i +: 32];
        e_rack = 1; m_rbusy = 0; e_rdata = merged;
      end else if (m_n - m_rstart == TO) begin
        e_rack = 1; m_rbusy = 0; rto = 1; e_rdata = TD;
      end
    end
    if (up_status_clr) begin
      e_tcnt = 0; e_taddr = '0; e_multi = 0; e_proto = 0;
    end else begin
      e_tcnt = e_tcnt + int'(wto) + int'(rto);
      if (e_tcnt > 65535) e_tcnt = 65535;
      if (wto) e_taddr = e_slv_waddr;
      else if (rto) e_taddr = e_slv_raddr;
      if (multi_set) e_multi = 1;
      if (proto_set) e_proto = 1;
    end
  endtask

  always @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge up_clk) begin
    #1;
    check("slv_wreq",   32'(slv_wreq),         32'(e_slv_wreq));
    check("slv_waddr",  32'(slv_waddr),        32'(e_slv_waddr));
    check("slv_wdata",  slv_wdata,             e_slv_wdata);
    check("slv_rreq",   32'(slv_rreq),         32'(e_slv_rreq));
    check("slv_raddr",  32'(slv_raddr),        32'(e_slv_raddr));
    check("up_wack",    32'(up_wack),          32'(e_wack));
    check("up_rack",    32'(up_rack),          32'(e_rack));
    check("up_rdata",   up_rdata,              e_rdata);
    check("tmo_cnt",    32'(up_timeout_cnt),   32'(e_tcnt));
    check("tmo_addr",   32'(up_timeout_addr),  32'(e_taddr));
    check("multi_err",  32'(up_multi_ack_err), 32'(e_multi));
    check("proto_err",  32'(up_proto_err),     32'(e_proto));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge up_clk);
    #2;
  endtask

  function automatic logic [NS-1:0] rand_ack(input bit busy);
    logic [NS-1:0] a;
    a = '0;
    if (busy) begin
      if ($urandom_range(0, 19) == 0) a = NS'($urandom_range(1, (1 << NS) - 1));
    end else if ($urandom_range(0, 29) == 0) begin
      a[$urandom_range(0, NS - 1)] = 1'b1;
    end
    return a;
  endfunction

  initial begin
    int cyc, wcyc, rcyc, wcount, rcount;

    repeat (3) tick();
    check("rst_wack",  32'(up_wack), 32'd0);
    check("rst_rdata", up_rdata, 32'd0);
    check("rst_tcnt",  32'(up_timeout_cnt), 32'd0);
    up_rstn = 1'b1;
    tick();

    // write acked by slave 1 two cycles after slv_wreq
    up_wreq = 1; up_waddr = 14'h0010; up_wdata = 32'h12345678;
    tick(); up_wreq = 0;
    check("t1_slv_wreq_c1", 32'(slv_wreq), 32'd1);
    check("t1_slv_waddr",   32'(slv_waddr), 32'h10);
    tick();
    check("t1_wack_c2", 32'(up_wack), 32'd0);
    tick(); slv_wack = 3'b010;
    check("t1_wack_c3", 32'(up_wack), 32'd0);
    tick(); slv_wack = '0;
    check("t1_wack_c4", 32'(up_wack), 32'd1);
    tick();
    check("t1_wack_c5", 32'(up_wack), 32'd0);
    check("t1_tcnt",    32'(up_timeout_cnt), 32'd0);

    // read answered by slave 2; non-acking slaves carry junk
    up_rreq = 1; up_raddr = 14'h0000;
    tick(); up_rreq = 0;
    tick();
    slv_rdata = {32'h00090062, 32'h0F0F0F0F, 32'hFFFF0000}; slv_rack = 3'b100;
    tick(); slv_rack = '0;
    check("t2_rack",  32'(up_rack), 32'd1);
    check("t2_rdata", up_rdata, 32'h00090062);
    tick();
    check("t2_hold",  up_rdata, 32'h00090062);

    // unmapped read times out
    up_rreq = 1; up_raddr = 14'h3FFF;
    rcyc = -1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      tick(); up_rreq = 0;
      if (up_rack) begin rcyc = cyc; break; end
    end
    check("t3_rack_cycle", 32'(rcyc), 32'd33);
    check("t3_rdata",      up_rdata, 32'hDEADDEAD);
    check("t3_tcnt",       32'(up_timeout_cnt), 32'd1);
    check("t3_taddr",      32'(up_timeout_addr), 32'h3FFF);
    tick();

    // two slaves ack together
    up_rreq = 1; up_raddr = 14'h0005;
    tick(); up_rreq = 0;
    slv_rdata = {32'hABCD0000, 32'h0000000F, 32'h0000F000}; slv_rack = 3'b011;
    tick(); slv_rack = '0;
    check("t4_rack",  32'(up_rack), 32'd1);
    check("t4_rdata", up_rdata, 32'h0000F00F);
    check("t4_multi", 32'(up_multi_ack_err), 32'd1);
    tick();
    check("t4_single_rack", 32'(up_rack), 32'd0);
    up_status_clr = 1;
    tick(); up_status_clr = 0;
    check("t4_multi_clr", 32'(up_multi_ack_err), 32'd0);
    check("t4_tcnt_clr",  32'(up_timeout_cnt), 32'd0);

    // simultaneous unacked write and read, plus a dropped second write
    up_wreq = 1; up_waddr = 14'h0123; up_rreq = 1; up_raddr = 14'h0456;
    tick(); up_wreq = 0; up_rreq = 0;
    tick(); up_wreq = 1; up_waddr = 14'h0777;
    tick(); up_wreq = 0;
    check("t5_proto", 32'(up_proto_err), 32'd1);
    wcyc = -1; rcyc = -1; wcount = 0; rcount = 0;
    for (cyc = 4; cyc <= 45; cyc++) begin
      tick();
      if (up_wack) begin wcount++; wcyc = cyc; end
      if (up_rack) begin rcount++; rcyc = cyc; end
    end
    check("t5_wack_cycle", 32'(wcyc), 32'd33);
    check("t5_rack_cycle", 32'(rcyc), 32'd33);
    check("t5_wack_count", 32'(wcount), 32'd1);
    check("t5_tcnt",       32'(up_timeout_cnt), 32'd2);
    check("t5_taddr",      32'(up_timeout_addr), 32'h0123);

    // reset in the middle of a write wait
    up_wreq = 1; up_waddr = 14'h0042; up_wdata = 32'hCAFEF00D;
    tick(); up_wreq = 0;
    tick(); tick();
    up_rstn = 0;
    #1;
    check("t6_rst_tcnt",  32'(up_timeout_cnt), 32'd0);
    check("t6_rst_proto", 32'(up_proto_err), 32'd0);
    check("t6_rst_waddr", 32'(slv_waddr), 32'd0);
    check("t6_rst_rdata", up_rdata, 32'd0);
    tick(); tick();
    up_rstn = 1;
    wcount = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (up_wack) wcount++;
    end
    check("t6_no_ack", 32'(wcount), 32'd0);
    up_wreq = 1; up_waddr = 14'h0020;
    tick(); up_wreq = 0;
    tick(); slv_wack = 3'b001;
    tick(); slv_wack = '0;
    check("t6_next_wack", 32'(up_wack), 32'd1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      tick();
      up_wreq       = ($urandom_range(0, 5) == 0);
      up_waddr      = AW'($urandom);
      up_wdata      = $urandom;
      up_rreq       = ($urandom_range(0, 5) == 0);
      up_raddr      = AW'($urandom);
      slv_rdata     = {$urandom, $urandom, $urandom};
      slv_wack      = rand_ack(m_wbusy);
      slv_rack      = rand_ack(m_rbusy);
      up_status_clr = ($urandom_range(0, 49) == 0);
    end
    tick();
    up_wreq = 0; up_rreq = 0; slv_wack = '0; slv_rack = '0; up_status_clr = 0;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
